// File: rtl/ir_prefetch_queue.sv
// Instruction register with prefetch queue: assembles 1/2-byte instructions from the
// fetch bus and buffers up to DEPTH decoded entries for the control unit.
module ir_prefetch_queue #(
  parameter int                   DATA_W    = 8,
  parameter int                   OPC_W     = 4,
  parameter int                   DEPTH     = 4,
  parameter logic [2**OPC_W-1:0]  LONG_MASK = 16'h0FF0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPC_W-1:0]             ins,
  output logic [DATA_W-OPC_W-1:0]      addr_reg,
  output logic [DATA_W-1:0]            addr_mem,
  output logic                         out_long,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH-1);

  typedef enum logic {S_OP, S_OPR} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  hold;
  logic               hold_ld;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [DATA_W-1:0]  q_first  [DEPTH];
  logic [DATA_W-1:0]  q_second [DEPTH];
  logic               q_long   [DEPTH];

  logic               accept, push, pop;
  logic [DATA_W-1:0]  push_first, push_second;
  logic               push_long;

  // Ready comes from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) state <= S_OP;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    hold_ld     = 1'b0;
    push_first  = in_data;
    push_second = '0;
    push_long   = 1'b0;
    if (accept) begin
      case (state)
        S_OP: begin
          if (LONG_MASK[in_data[DATA_W-1 -: OPC_W]]) begin
            hold_ld   = 1'b1;
            state_nxt = S_OPR;
          end else begin
            push = 1'b1;
          end
        end
        S_OPR: begin
          push        = 1'b1;
          push_first  = hold;
          push_second = in_data;
          push_long   = 1'b1;
          state_nxt   = S_OP;
        end
        default: state_nxt = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) hold <= '0;
    else if (hold_ld)    hold <= in_data;
  end

  // Flush drops any push/pop of the same cycle along with the queue contents.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      q_first[wr_ptr]  <= push_first;
      q_second[wr_ptr] <= push_second;
      q_long[wr_ptr]   <= push_long;
    end
  end

  always_comb begin
    ins      = '0;
    addr_reg = '0;
    addr_mem = '0;
    out_long = 1'b0;
    if (out_valid) begin
      ins      = q_first[rd_ptr][DATA_W-1 -: OPC_W];
      addr_reg = q_first[rd_ptr][DATA_W-OPC_W-1:0];
      addr_mem = q_second[rd_ptr];
      out_long = q_long[rd_ptr];
    end
  end
endmodule
